// File: rtl/barrelshift32_left_pipe.sv
// ----------------------------------------------------------------------------
// barrelshift32_left_pipe
//
// Pipelined logical left barrel shifter. Stage k applies a shift of 2^k when
// bit k of the operand's shift amount is set, and each stage is registered, so
// a result appears SHAMT_W cycles after its operand is accepted. The whole pipe
// advances together whenever the output register is empty or being drained.
//
// Optional feature macro: BSL_ROTATE_EN
//   When defined, the in_rot port exists and selects rotate-left per operand
//   (bits leaving the MSB re-enter at the LSB). When undefined, zero fill only.
//
// Ports
//   clk        in   1        clock, all state updates on rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operand present
//   in_ready   out  1        pipe accepts an operand this cycle
//   in_data    in   WIDTH    operand
//   in_shamt   in   SHAMT_W  left-shift amount
//   in_rot     in   1        rotate select (BSL_ROTATE_EN only)
//   out_valid  out  1        out_data holds a result
//   out_ready  in   1        consumer takes the result this cycle
//   out_data   out  WIDTH    shifted result (registered)
//   busy       out  1        any stage holds a valid operand
// ----------------------------------------------------------------------------
module barrelshift32_left_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
`ifdef BSL_ROTATE_EN
  input  logic               in_rot,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int NS = SHAMT_W;

  // Stage registers. The shift amount and rotate flag are only needed by the
  // stages that still have a level to apply, so the last stage carries data only.
  logic [NS-1:0]      valid_q;
  logic [WIDTH-1:0]   data_q  [NS];
  logic [SHAMT_W-1:0] shamt_q [NS-1];
`ifdef BSL_ROTATE_EN
  logic [NS-2:0]      rot_q;
`endif

  // Per-stage inputs and the shifted value each stage would capture.
  logic [WIDTH-1:0]   st_data  [NS];
  logic [SHAMT_W-1:0] st_shamt [NS];
  logic [NS-1:0]      st_rot;
  logic [NS-1:0]      st_vld;
  logic [WIDTH-1:0]   data_d   [NS];

  logic adv;

  // Left shift by n; with rot set the bits pushed out of the top re-enter at
  // the bottom. The doubled word avoids a WIDTH-n subtraction.
  function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0]   d,
                                           input logic [SHAMT_W-1:0] n,
                                           input logic               rot);
    logic [2*WIDTH-1:0] dbl;
    dbl = {d, d} << n;
    return rot ? dbl[2*WIDTH-1:WIDTH] : (d << n);
  endfunction

  assign adv      = !valid_q[NS-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    st_data[0]  = in_data;
    st_shamt[0] = in_shamt;
    st_vld[0]   = in_valid;
    for (int k = 1; k < NS; k++) begin
      st_data[k]  = data_q[k-1];
      st_shamt[k] = shamt_q[k-1];
      st_vld[k]   = valid_q[k-1];
    end
`ifdef BSL_ROTATE_EN
    st_rot[0] = in_rot;
    for (int k = 1; k < NS; k++) st_rot[k] = rot_q[k-1];
`else
    st_rot = '0;
`endif
    // Masking the amount down to bit k gives either 0 or 2^k for this level.
    for (int k = 0; k < NS; k++) begin
      data_d[k] = shl(st_data[k], st_shamt[k] & (SHAMT_W'(1) << k), st_rot[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < NS; k++) data_q[k] <= '0;
      for (int k = 0; k < NS - 1; k++) shamt_q[k] <= '0;
`ifdef BSL_ROTATE_EN
      rot_q <= '0;
`endif
    end else if (adv) begin
      // in_ready equals adv, so in_valid alone marks a transfer here.
      valid_q[0] <= in_valid;
      for (int k = 1; k < NS; k++) valid_q[k] <= valid_q[k-1];
      // Bubbles leave payload registers untouched so undriven inputs never
      // propagate toward out_data.
      for (int k = 0; k < NS; k++) begin
        if (st_vld[k]) data_q[k] <= data_d[k];
      end
      for (int k = 0; k < NS - 1; k++) begin
        if (st_vld[k]) shamt_q[k] <= st_shamt[k];
      end
`ifdef BSL_ROTATE_EN
      for (int k = 0; k < NS - 1; k++) begin
        if (st_vld[k]) rot_q[k] <= st_rot[k];
      end
`endif
    end
  end

  assign out_valid = valid_q[NS-1];
  assign out_data  = data_q[NS-1];
  assign busy      = |valid_q;

endmodule
